// File: rtl/shift_register_ctl.sv
// I2C byte shifter: parallel load, MSB-first serial shift, bit count, done pulse.
// Optional ACK slot after the data bits: define SHIFT_REG_ACK_SLOT_EN.
module shift_register_ctl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] ins,
  input  logic             shift_en,
  input  logic             sdi,
  input  logic             abort,
  input  logic             ack_drv,
  output logic             sdo,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             done,
  output logic             ack_rcv
);

`ifdef SHIFT_REG_ACK_SLOT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    // abort wins over everything and keeps the partial byte visible
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            out_d   = ins;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            out_d = {out_q[WIDTH-2:0], sdi};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_bit) begin
`ifdef SHIFT_REG_ACK_SLOT_EN
              state_d = ACK;
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end
          end
        end
`ifdef SHIFT_REG_ACK_SLOT_EN
        ACK: begin
          if (shift_en) begin
            ack_d   = sdi;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
`endif
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    sdo = 1'b1;
    unique case (state_q)
      IDLE:  sdo = 1'b1;
      SHIFT: sdo = out_q[WIDTH-1];
`ifdef SHIFT_REG_ACK_SLOT_EN
      ACK:     sdo = ack_drv;
      default: sdo = 1'b1;
`endif
    endcase
  end

  assign out     = out_q;
  assign bit_cnt = cnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

`ifdef SHIFT_REG_ACK_SLOT_EN
  assign ack_rcv = ack_q;
`else
  logic unused_ack;
  assign unused_ack = ack_drv ^ ack_q;
  assign ack_rcv    = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_ctl.sv
// Directed bench for shift_register_ctl (WIDTH=8).
// Works in both builds; ACK-slot steps follow SHIFT_REG_ACK_SLOT_EN.
module tb_shift_register_ctl;

  logic       clock;
  logic       reset_n;
  logic       load;
  logic [7:0] ins;
  logic       shift_en;
  logic       sdi;
  logic       abort;
  logic       ack_drv;
  logic       sdo;
  logic [7:0] out;
  logic [3:0] bit_cnt;
  logic       busy;
  logic       done;
  logic       ack_rcv;

  int checks = 0;
  int errors = 0;

  shift_register_ctl #(.WIDTH(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .ins      (ins),
    .shift_en (shift_en),
    .sdi      (sdi),
    .abort    (abort),
    .ack_drv  (ack_drv),
    .sdo      (sdo),
    .out      (out),
    .bit_cnt  (bit_cnt),
    .busy     (busy),
    .done     (done),
    .ack_rcv  (ack_rcv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic b);
    shift_en = 1'b1;
    sdi      = b;
    tick();
    shift_en = 1'b0;
  endtask

  logic [7:0] sdi_v;
  logic [7:0] sdo_v;

  initial begin
    reset_n  = 1'b0;
    load     = 1'b0;
    ins      = 8'h00;
    shift_en = 1'b0;
    sdi      = 1'b0;
    abort    = 1'b0;
    ack_drv  = 1'b0;
    sdi_v    = 8'b0011_1100;
    sdo_v    = 8'b1010_0101;

    #3;
    check("rst_out", 32'(out), 32'h00);
    check("rst_cnt", 32'(bit_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd1);
    check("rst_ack", 32'(ack_rcv), 32'd0);
    #10 reset_n = 1'b1;
    tick();

    // load 0xA5 and shift 8 bits
    ins  = 8'hA5;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_out", 32'(out), 32'hA5);
    check("ld_cnt", 32'(bit_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sdo_%0d", i), 32'(sdo), 32'(sdo_v[7-i]));
      strobe(sdi_v[7-i]);
      if (i < 7) check($sformatf("nodone_%0d", i), 32'(done), 32'd0);
    end
    check("a5_out", 32'(out), 32'h3C);
    check("a5_cnt", 32'(bit_cnt), 32'd8);
`ifdef SHIFT_REG_ACK_SLOT_EN
    check("slot_done", 32'(done), 32'd0);
    check("slot_busy", 32'(busy), 32'd1);
    check("slot_sdo0", 32'(sdo), 32'd0);
    ack_drv = 1'b1;
    #1;
    check("slot_sdo1", 32'(sdo), 32'd1);
    ack_drv = 1'b0;
    strobe(1'b1);
    check("slot_ack", 32'(ack_rcv), 32'd1);
    check("slot_out", 32'(out), 32'h3C);
`endif
    check("a5_done", 32'(done), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);
    check("a5_sdo", 32'(sdo), 32'd1);
    tick();
    check("a5_pulse", 32'(done), 32'd0);
    check("a5_hold", 32'(bit_cnt), 32'd8);

    // strobes in IDLE are ignored
    for (int i = 0; i < 3; i++) strobe(1'b1);
    check("idle_out", 32'(out), 32'h3C);
    check("idle_cnt", 32'(bit_cnt), 32'd8);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // load while busy is ignored
    ins  = 8'h5A;
    load = 1'b1;
    tick();
    load = 1'b0;
    strobe(1'b0);
    strobe(1'b0);
    check("lb_out0", 32'(out), 32'h68);
    check("lb_cnt0", 32'(bit_cnt), 32'd2);
    ins  = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("lb_out1", 32'(out), 32'h68);
    check("lb_cnt1", 32'(bit_cnt), 32'd2);
    check("lb_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) strobe(1'b1);
`ifdef SHIFT_REG_ACK_SLOT_EN
    check("lb_slot", 32'(done), 32'd0);
    strobe(1'b0);
    check("lb_ack", 32'(ack_rcv), 32'd0);
`endif
    check("lb_out2", 32'(out), 32'h3F);
    check("lb_cnt2", 32'(bit_cnt), 32'd8);
    check("lb_done", 32'(done), 32'd1);
    tick();

    // load with shift_en together: load only
    ins      = 8'h80;
    load     = 1'b1;
    shift_en = 1'b1;
    sdi      = 1'b1;
    tick();
    load     = 1'b0;
    shift_en = 1'b0;
    check("ls_out", 32'(out), 32'h80);
    check("ls_cnt", 32'(bit_cnt), 32'd0);
    check("ls_sdo", 32'(sdo), 32'd1);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    check("ab_pre", 32'(out), 32'h07);
    check("ab_sdo0", 32'(sdo), 32'd0);
    // abort beats simultaneous load and strobe
    abort    = 1'b1;
    load     = 1'b1;
    shift_en = 1'b1;
    ins      = 8'hFF;
    tick();
    abort    = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_cnt", 32'(bit_cnt), 32'd3);
    check("ab_out", 32'(out), 32'h07);
    check("ab_sdo", 32'(sdo), 32'd1);
    check("ab_done0", 32'(done), 32'd0);
    tick();
    check("ab_done1", 32'(done), 32'd0);

    // async reset mid-transfer
    ins  = 8'hC3;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) strobe(1'b0);
    check("mr_cnt", 32'(bit_cnt), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("mr_out", 32'(out), 32'h00);
    check("mr_cnt0", 32'(bit_cnt), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_sdo", 32'(sdo), 32'd1);
    check("mr_done", 32'(done), 32'd0);
    #10 reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
